// File: rtl/pe_row_feeder_pkg.sv
// Shared types and helpers for the PE row feeder.
//   state_t      : feeder FSM states
//   LFSR_TAPS_16 : Fibonacci tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   bitrev_msb   : reverse the low w bits of x into the top w bits of a 16-bit word
package pe_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOADW = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits 15,13,12,10 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  // The bit-reversed run counter forms a low-discrepancy weight-side sequence.
  function automatic logic [15:0] bitrev_msb(input logic [15:0] x, input int unsigned w);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < w) r[4'(15 - i)] = x[4'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random word source (shift left, feedback into bit 0).
// Ports: clk, rst (async, active-high), reload (load seed), step (advance one state),
//        value (current LFSR state, never zero).
module lfsr_rng
  import pe_feeder_pkg::*;
#(
  parameter int unsigned        IWIDTH = 16,
  parameter logic [IWIDTH-1:0]  SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              step,
  output logic [IWIDTH-1:0] value
);

  // A zero seed would lock the register at zero forever.
  localparam logic [IWIDTH-1:0] SEED_EFF = (SEED == '0) ? IWIDTH'(1) : SEED;
  localparam logic [IWIDTH-1:0] TAPS     = IWIDTH'(LFSR_TAPS_16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         value <= SEED_EFF;
    else if (reload) value <= SEED_EFF;
    else if (step)   value <= {value[IWIDTH-2:0], ^(value & TAPS)};
  end

endmodule

// File: rtl/pe_row_feeder.sv
// Edge driver for one row of the uGEMM-rate systolic array.
// Accepts a MAC job (ifm, weight, sign, run length - 1), loads the weight for one
// cycle, then streams the rate-coded input bit and bit-reversed randW words while
// sequencing en/clr/mac_done for the first PE.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        job handshake; in_ifm, in_wght, in_wght_sign, in_cycles job payload
//   abort                    synchronous cancel while loading or running
//   ifm_dff, wght, wght_sign PE operands; randW, randW_inv weight-side random words
//   en_*/clr_*/mac_done      PE control; out_done one-cycle completion pulse
module pe_row_feeder
  import pe_feeder_pkg::*;
#(
  parameter int unsigned        IWIDTH = 16,
  parameter int unsigned        CWIDTH = 8,
  parameter logic [IWIDTH-1:0]  SEED_I = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_ifm,
  input  logic [IWIDTH-1:0] in_wght,
  input  logic              in_wght_sign,
  input  logic [CWIDTH-1:0] in_cycles,
  input  logic              abort,
  output logic              ifm_dff,
  output logic [IWIDTH-1:0] wght,
  output logic              wght_sign,
  output logic [IWIDTH-1:0] randW,
  output logic [IWIDTH-1:0] randW_inv,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o,
  output logic              mac_done,
  output logic              out_done
);

  state_t            state_q, state_d;
  logic [IWIDTH-1:0] ifm_q;
  logic [CWIDTH-1:0] cyc_q, cnt_q;
  logic [IWIDTH-1:0] lfsr;
  logic              hs;
  logic              last_d;

  logic              in_ready_d, ifm_dff_d, wght_sign_d;
  logic [IWIDTH-1:0] wght_d, randw_d, randw_inv_d;
  logic              en_i_d, clr_i_d, en_w_d, clr_w_d, en_o_d, clr_o_d, mac_done_d, out_done_d;

  assign hs = in_valid && in_ready;

  lfsr_rng #(.IWIDTH(IWIDTH), .SEED(SEED_I)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .reload (state_d == LOADW),
    .step   (state_d == RUN),
    .value  (lfsr)
  );

  // Next state and next output values; outputs are registered with the state they belong to.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    ifm_dff_d   = 1'b0;
    wght_d      = wght;
    wght_sign_d = wght_sign;
    randw_d     = '0;
    randw_inv_d = '0;
    en_i_d      = 1'b0;
    clr_i_d     = 1'b0;
    en_w_d      = 1'b0;
    clr_w_d     = 1'b0;
    en_o_d      = 1'b0;
    clr_o_d     = 1'b0;
    mac_done_d  = 1'b0;
    out_done_d  = 1'b0;
    last_d      = 1'b0;

    case (state_q)
      IDLE:    if (hs) state_d = LOADW;
      LOADW:   state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort)         state_d = IDLE;
        else if (mac_done) state_d = DONE;
        else               state_d = RUN;
      end
      DONE:    state_d = hs ? LOADW : IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE: in_ready_d = 1'b1;
      LOADW: begin
        // Entry into LOADW only happens on a handshake, so the payload is live now.
        en_w_d      = 1'b1;
        clr_i_d     = 1'b1;
        wght_d      = in_wght;
        wght_sign_d = in_wght_sign;
      end
      RUN: begin
        last_d      = (cnt_q == cyc_q);
        en_i_d      = 1'b1;
        en_o_d      = 1'b1;
        clr_o_d     = (state_q == LOADW);
        mac_done_d  = last_d;
        ifm_dff_d   = (ifm_q > lfsr);
        randw_d     = IWIDTH'(bitrev_msb(16'(cnt_q), CWIDTH));
        randw_inv_d = ~randw_d;
      end
      DONE: begin
        in_ready_d = 1'b1;
        out_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      ifm_dff   <= 1'b0;
      wght      <= '0;
      wght_sign <= 1'b0;
      randW     <= '0;
      randW_inv <= '0;
      en_i      <= 1'b0;
      clr_i     <= 1'b0;
      en_w      <= 1'b0;
      clr_w     <= 1'b0;
      en_o      <= 1'b0;
      clr_o     <= 1'b0;
      mac_done  <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      ifm_dff   <= ifm_dff_d;
      wght      <= wght_d;
      wght_sign <= wght_sign_d;
      randW     <= randw_d;
      randW_inv <= randw_inv_d;
      en_i      <= en_i_d;
      clr_i     <= clr_i_d;
      en_w      <= en_w_d;
      clr_w     <= clr_w_d;
      en_o      <= en_o_d;
      clr_o     <= clr_o_d;
      mac_done  <= mac_done_d;
      out_done  <= out_done_d;
    end
  end

  // Job payload and run counter; the counter holds on the last code so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifm_q <= '0;
      cyc_q <= '0;
      cnt_q <= '0;
    end else begin
      if (hs) begin
        ifm_q <= in_ifm;
        cyc_q <= in_cycles;
      end
      if (state_d == LOADW)                cnt_q <= '0;
      else if (state_d == RUN && !last_d)  cnt_q <= cnt_q + CWIDTH'(1);
    end
  end

endmodule

// File: doc/pe_row_feeder.md
Name: pe_row_feeder

Overview:
Edge driver for one row of the 16-bit uGEMM-rate systolic array. It is the transmitter side of the PE operand and control interface.
- Accepts one binary MAC job per handshake: input magnitude, weight and weight sign.
- Loads the weight into the PE chain, then streams the rate-coded input bit (LFSR comparator) and the low-discrepancy randW/randW_inv words.
- Sequences en/clr/mac_done so the first PE sees a well-formed MAC window.

Parameters:
IWIDTH, 16, data/random word width; only 16 is supported by the LFSR taps.
CWIDTH, 8, run-length counter width; must satisfy CWIDTH <= IWIDTH.
SEED_I, 16'hACE1, LFSR seed for the input comparator; a value of 0 is replaced by 1.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  job offered
in_ready  out  1  job accepted when in_valid && in_ready
in_ifm  in  IWIDTH  input magnitude (unsigned)
in_wght  in  IWIDTH  weight magnitude
in_wght_sign  in  1  weight sign
in_cycles  in  CWIDTH  run length minus 1
abort  in  1  synchronous job cancel
ifm_dff  out  1  rate-coded input bit to PE
wght  out  IWIDTH  weight word to PE
wght_sign  out  1  held weight sign
randW  out  IWIDTH  weight-side random word
randW_inv  out  IWIDTH  bitwise inverse of randW
en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done  out  1 each  PE control
out_done  out  1  one-cycle pulse when a job completes

Behaviour:
- Reset (asynchronous):
  - state=IDLE; all outputs 0 except in_ready=1.
  - LFSR=SEED_I; counter=0; job registers=0.
- FSM states: IDLE, LOADW, RUN, DONE. All outputs are registered, so each output reflects the state it was driven for.
- IDLE:
  - in_ready=1.
  - On handshake: latch in_ifm, in_wght, in_wght_sign, in_cycles; go to LOADW.
- LOADW (exactly 1 cycle):
  - en_w=1, clr_i=1, wght=latched weight, wght_sign=latched sign.
  - Reload LFSR=SEED_I and counter=0.
  - Go to RUN.
- RUN (in_cycles+1 cycles):
  - en_i=1 and en_o=1 every cycle.
  - clr_o=1 only on the first RUN cycle.
  - mac_done=1 only on the last RUN cycle; when in_cycles=0 the single cycle carries both clr_o and mac_done.
  - ifm_dff = (in_ifm > lfsr), using the current LFSR value; the LFSR then advances one step.
  - randW = {bitrev(cnt[CWIDTH-1:0]), (IWIDTH-CWIDTH) zeros}; randW_inv = ~randW; cnt increments.
  - Exit to DONE after the cycle where cnt == in_cycles.
- DONE (1 cycle):
  - out_done=1, in_ready=1, en/clr/mac_done all 0.
  - A handshake here goes directly to LOADW (back-to-back jobs, no IDLE bubble); otherwise go to IDLE.
- Between jobs, wght and wght_sign hold their last value; ifm_dff, randW and randW_inv drive 0 outside RUN.
- LFSR: Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0. The period is 65535, the all-zero state is never reached, and lfsr ranges over 1..0xFFFF.
- Comparator boundaries:
  - in_ifm=0 gives ifm_dff always 0.
  - in_ifm=0xFFFF gives 1 except when lfsr=0xFFFF.
- Counter wrap: in_cycles = 2^CWIDTH-1 runs all 2^CWIDTH codes; cnt never wraps within a job.
- abort:
  - In LOADW or RUN: next state IDLE, with no mac_done and no out_done; control outputs drop to 0 the following cycle.
  - In IDLE or DONE: ignored.
  - abort together with in_valid in DONE: abort is ignored and the handshake wins.
- in_valid while busy: not accepted; the value is held by the upstream producer.
- Asynchronous reset mid-job: immediate return to the reset values; the partial job is lost.

Decomposition:
- Package pe_feeder_pkg:
  - state enum typedef (IDLE/LOADW/RUN/DONE);
  - LFSR tap mask constant for width 16;
  - bitrev function.
- Sub-module lfsr_rng (IWIDTH, SEED; ports reload, step, value): reusable for future column feeders. The counter and bit-reverse stay inline.

Test Plan:
1. Reset asserted mid-RUN -> in_ready=1, all control outputs 0 within the same cycle; next job runs normally.
2. Job in_cycles=3, CWIDTH=8 -> LOADW shows en_w=1 and clr_i=1; 4 RUN cycles follow.
   - randW = 0x0000, 0x8000, 0x4000, 0xC000; randW_inv = 0xFFFF, 0x7FFF, 0xBFFF, 0x3FFF.
   - clr_o on cycle 1, mac_done on cycle 4, out_done on the next cycle.
3. in_ifm=0 and in_ifm=0xFFFF, in_cycles=255 -> ifm_dff ones count 0 and 256 respectively.
   - The LFSR visits only 256 distinct nonzero values from SEED_I, none equal to 0xFFFF; the bench checks against a reference LFSR model.
4. Two jobs with in_valid held through DONE -> second LOADW in the cycle after DONE; the second job's ifm_dff sequence is identical to the first (LFSR reseeded).
5. abort asserted in RUN cycle 2 of a 4-cycle job -> no mac_done, no out_done, IDLE next cycle, in_ready=1.
6. in_cycles=0 -> a single RUN cycle with clr_o=1 and mac_done=1 together, randW=0x0000.
